// File: rtl/turnike_gecis_cozucu.sv
// -----------------------------------------------------------------------------
// turnike_gecis_cozucu -- turnstile passage decoder
//
// Takes entry/exit grants from the button/indicator block, unlocks the arm,
// decodes the two arm sensors into a rotation direction and reports completed
// passages. Forced or reverse rotation raises an alarm; a grant that is never
// used expires after GRANT_TIMEOUT_CYC cycles.
//
// Handshake: there is no valid/ready flow control here. Every *_pulse input
// and output is a single-cycle strobe; a strobe is consumed in the cycle it
// is high and is dropped if the FSM is not in a state that accepts it.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   sens_a_n/_b_n    raw arm sensors, active-low, asynchronous to clk
//   grant_in/out     one-cycle grant strobes (entry / exit)
//   alarm_clr        one-cycle alarm acknowledge
//   lock             1 = arm locked
//   entry_pulse      one cycle per completed entry
//   exit_pulse       one cycle per completed exit
//   timeout_pulse    one cycle when an unused grant expires
//   alarm            forced / invalid rotation flag
//   entry_count      completed entries, saturating
//   exit_count       completed exits, saturating
//   state_dbg        current FSM state (0 IDLE, 1 ARMED, 2 ROT1, 3 ROT2,
//                    4 ROT3, 5 ALARM)
// -----------------------------------------------------------------------------
module turnike_gecis_cozucu #(
  parameter int DEBOUNCE_CYC      = 480_000,
  parameter int GRANT_TIMEOUT_CYC = 100_000_000,
  parameter int COUNT_W           = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sens_a_n,
  input  logic               sens_b_n,
  input  logic               grant_in,
  input  logic               grant_out,
  input  logic               alarm_clr,
  output logic               lock,
  output logic               entry_pulse,
  output logic               exit_pulse,
  output logic               timeout_pulse,
  output logic               alarm,
  output logic [COUNT_W-1:0] entry_count,
  output logic [COUNT_W-1:0] exit_count,
  output logic [2:0]         state_dbg
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam int TO_W = $clog2(GRANT_TIMEOUT_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(GRANT_TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    ROT1  = 3'd2,
    ROT2  = 3'd3,
    ROT3  = 3'd4,
    ALARM = 3'd5
  } state_e;

  // ---------------------------------------------------------------------------
  // Sensor path: invert, two-flop synchronize, debounce. Index 1 = A, 0 = B.
  // ---------------------------------------------------------------------------
  logic [1:0]      sync1_q, sync2_q, deb_q;
  logic [DB_W-1:0] db_cnt_q [2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= 2'b00;
      sync2_q     <= 2'b00;
      deb_q       <= 2'b00;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
    end else begin
      sync1_q <= {~sens_a_n, ~sens_b_n};
      sync2_q <= sync1_q;
      for (int i = 0; i < 2; i++) begin
        // A sample equal to the accepted level restarts the run; the
        // DEBOUNCE_CYC-th consecutive differing sample flips the level.
        if (sync2_q[i] == deb_q[i]) begin
          db_cnt_q[i] <= '0;
        end else if (db_cnt_q[i] == DB_LAST) begin
          deb_q[i]    <= sync2_q[i];
          db_cnt_q[i] <= '0;
        end else begin
          db_cnt_q[i] <= db_cnt_q[i] + 1'b1;
        end
      end
    end
  end

  logic [1:0] ab;
  assign ab = deb_q;

  // ---------------------------------------------------------------------------
  // Passage FSM with registered outputs.
  // dir_q = 1 for entry, 0 for exit. Entry rotates 00-10-11-01-00, exit the
  // mirror image, so the first and third steps swap with direction.
  // ---------------------------------------------------------------------------
  state_e             state_q;
  logic               dir_q;
  logic [TO_W-1:0]    timer_q;
  logic               lock_q, alarm_q;
  logic               entry_pulse_q, exit_pulse_q, timeout_pulse_q;
  logic [COUNT_W-1:0] entry_count_q, exit_count_q;

  logic [1:0] e1, e3;
  assign e1 = dir_q ? 2'b10 : 2'b01;
  assign e3 = ~e1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      dir_q           <= 1'b1;
      timer_q         <= '0;
      lock_q          <= 1'b1;
      alarm_q         <= 1'b0;
      entry_pulse_q   <= 1'b0;
      exit_pulse_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;
      entry_count_q   <= '0;
      exit_count_q    <= '0;
    end else begin
      entry_pulse_q   <= 1'b0;
      exit_pulse_q    <= 1'b0;
      timeout_pulse_q <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (ab != 2'b00) begin
            state_q <= ALARM;
            lock_q  <= 1'b1;
            alarm_q <= 1'b1;
          end else if (grant_in || grant_out) begin
            // Simultaneous grants resolve to entry.
            state_q <= ARMED;
            dir_q   <= grant_in;
            timer_q <= '0;
            lock_q  <= 1'b0;
          end
        end

        ARMED: begin
          if (ab == e1) begin
            state_q <= ROT1;
          end else if (ab != 2'b00) begin
            state_q <= ALARM;
            lock_q  <= 1'b1;
            alarm_q <= 1'b1;
          end else if (timer_q == TO_LAST) begin
            state_q         <= IDLE;
            lock_q          <= 1'b1;
            timeout_pulse_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        // Timer is frozen while the arm is off its rest position; a back-off
        // to 00 resumes it from where it stopped.
        ROT1: begin
          if (ab == 2'b11) begin
            state_q <= ROT2;
          end else if (ab == 2'b00) begin
            state_q <= ARMED;
          end else if (ab != e1) begin
            state_q <= ALARM;
            lock_q  <= 1'b1;
            alarm_q <= 1'b1;
          end
        end

        ROT2: begin
          if (ab == e3) begin
            state_q <= ROT3;
          end else if (ab == e1) begin
            state_q <= ROT1;
          end else if (ab != 2'b11) begin
            state_q <= ALARM;
            lock_q  <= 1'b1;
            alarm_q <= 1'b1;
          end
        end

        ROT3: begin
          if (ab == 2'b00) begin
            state_q <= IDLE;
            lock_q  <= 1'b1;
            if (dir_q) begin
              entry_pulse_q <= 1'b1;
              if (entry_count_q != '1) entry_count_q <= entry_count_q + 1'b1;
            end else begin
              exit_pulse_q <= 1'b1;
              if (exit_count_q != '1) exit_count_q <= exit_count_q + 1'b1;
            end
          end else if (ab == 2'b11) begin
            state_q <= ROT2;
          end else if (ab != e3) begin
            state_q <= ALARM;
            lock_q  <= 1'b1;
            alarm_q <= 1'b1;
          end
        end

        ALARM: begin
          // Acknowledge only takes effect with the arm at rest.
          if (alarm_clr && (ab == 2'b00)) begin
            state_q <= IDLE;
            alarm_q <= 1'b0;
          end
        end

        default: begin
          state_q <= ALARM;
          lock_q  <= 1'b1;
          alarm_q <= 1'b1;
        end
      endcase
    end
  end

  assign lock          = lock_q;
  assign alarm         = alarm_q;
  assign entry_pulse   = entry_pulse_q;
  assign exit_pulse    = exit_pulse_q;
  assign timeout_pulse = timeout_pulse_q;
  assign entry_count   = entry_count_q;
  assign exit_count    = exit_count_q;
  assign state_dbg     = state_q;

endmodule
